uart_prog_loader: RTL

Synthesizable boot loader that receives a length-prefixed program image from a UART receiver and writes it into instruction memory. It is the hardware counterpart of the host/bench byte protocol: a little-endian size header followed by payload bytes. It generalises that protocol with a parametrised header width, memory word width and capacity check, plus an optional trailing checksum. It sits between the UART RX byte interface and the instruction-memory write port, and holds the core off until `done`.

---
 rtl/uart_prog_loader_if.sv | 22 ++
 rtl/uart_prog_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader_if.sv
// UART RX byte stream plus instruction-memory write port.
// The loader takes the slave side; the byte source / memory take the master side.
interface uart_prog_loader_if #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 12
);
   logic [7:0]              rx_data;
   logic                    rx_valid;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [8*WORD_BYTES-1:0] mem_wdata;

   modport slave (
      input  rx_data, rx_valid,
      output mem_we, mem_addr, mem_wdata
   );

   modport master (
      output rx_data, rx_valid,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/uart_prog_loader.sv
// Boot loader: little-endian size header, payload packed into memory
// words, optional trailing 8-bit additive checksum.
module uart_prog_loader #(
   parameter int WORD_BYTES = 4,
   parameter int ADDR_W     = 12,
   parameter int HDR_BYTES  = 4,
   parameter int MAX_BYTES  = 16384,
   parameter int CHECKSUM   = 0
) (
   input  logic                clk,
   input  logic                rst,
   uart_prog_loader_if.slave   bus,
   input  logic                restart,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code
);
   localparam int DW = 8 * WORD_BYTES;

   typedef enum logic [2:0] {
      S_HDR, S_DATA, S_LAST, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [1:0]        hcnt_q;
   logic [31:0]       size_q;
   logic [31:0]       byte_cnt_q;
   logic [7:0]        sum_q;
   logic [DW-1:0]     buf_q;
   logic              last_wr_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DW-1:0]     mem_wdata_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [1:0]        err_code_q;

   logic              rx_ok;
   logic              hdr_last;
   logic              pay_last;
   logic              top_lane;
   logic [31:0]       size_d;
   logic [31:0]       cnt_d;
   logic [31:0]       lane;
   logic [DW-1:0]     word_d;

   always_comb begin
      rx_ok    = bus.rx_valid & ~restart;
      size_d   = size_q | ({24'd0, bus.rx_data} << {hcnt_q, 3'b000});
      hdr_last = (hcnt_q == 2'(HDR_BYTES - 1));
      cnt_d    = byte_cnt_q + 32'd1;
      pay_last = (cnt_d == size_q);
      lane     = byte_cnt_q % 32'(WORD_BYTES);
      top_lane = (lane == 32'(WORD_BYTES - 1));
      word_d   = buf_q;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (lane == 32'(i)) word_d[i*8 +: 8] = bus.rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state_q     <= S_HDR;
         hcnt_q      <= '0;
         size_q      <= '0;
         byte_cnt_q  <= '0;
         sum_q       <= '0;
         buf_q       <= '0;
         last_wr_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         mem_we_q <= 1'b0;
         // The final word keeps its address so mem_addr stays inside the image
         if (mem_we_q && !last_wr_q) mem_addr_q <= mem_addr_q + ADDR_W'(1);
         unique case (state_q)
            S_HDR: if (rx_ok) begin
               busy_q <= 1'b1;
               size_q <= size_d;
               hcnt_q <= hcnt_q + 2'd1;
               if (hdr_last) begin
                  if (size_d > 32'(MAX_BYTES)) begin
                     state_q    <= S_ERR;
                     err_q      <= 1'b1;
                     err_code_q <= 2'b01;
                     busy_q     <= 1'b0;
                  end else if (size_d == 32'd0) begin
                     if (CHECKSUM != 0) begin
                        state_q <= S_CSUM;
                     end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: if (rx_ok) begin
               sum_q      <= sum_q + bus.rx_data;
               byte_cnt_q <= cnt_d;
               if (top_lane || pay_last) begin
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= word_d;
                  buf_q       <= '0;
                  last_wr_q   <= pay_last;
               end else begin
                  buf_q <= word_d;
               end
               if (pay_last) state_q <= (CHECKSUM != 0) ? S_CSUM : S_LAST;
            end
            S_LAST: begin
               state_q <= S_DONE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            S_CSUM: if (rx_ok) begin
               busy_q <= 1'b0;
               if (bus.rx_data == sum_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= S_ERR;
                  err_q      <= 1'b1;
                  err_code_q <= 2'b10;
               end
            end
            S_DONE, S_ERR: ;
            default: state_q <= S_HDR;
         endcase
      end
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
endmodule
